// File: rtl/cpu_mem_pkg.sv
// -----------------------------------------------------------------------------
// cpu_mem_pkg
//
// Shared definitions for the CPU data-memory path (load and store narrowing).
//
// Contents:
//   SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD : request size codes (req_size)
//   store_state_e                         : state encoding for the store narrower
//   is_misaligned()                       : alignment check shared with the load path
// -----------------------------------------------------------------------------
package cpu_mem_pkg;

    // Access size codes as driven by the memory stage.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Store narrower states: idle, first (or only) beat, second word beat.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BEAT0 = 2'b01,
        BEAT1 = 2'b10
    } store_state_e;

    // Returns 1 when an access of the given size cannot be issued at the given
    // byte offset. The reserved size code is always treated as a fault so
    // that neither the load nor the store path ever acts on it.
    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] addr_lo
    );
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage : cpu_mem_pkg

// File: rtl/store_narrow16.sv
// -----------------------------------------------------------------------------
// store_narrow16
//
// Narrows a 32-bit CPU store (byte / half / word) onto a 16-bit data-memory
// write bus. Byte and half stores take one beat, word stores take two beats
// (low half first). Misaligned or reserved-size requests are dropped with a
// one-cycle err pulse. Every output comes straight from a register.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   req_valid     : store request present (only looked at while idle)
//   req_ready     : high only in IDLE; the request is taken when both are high
//   req_addr      : byte address of the store
//   req_data      : store data, right-justified for byte/half
//   req_size      : 00 byte, 01 half, 10 word, 11 reserved
//   done          : one-cycle pulse, the cycle after the final beat handshake
//   err           : one-cycle pulse, the cycle after a rejected request
//   mem_wvalid    : write beat valid
//   mem_wready    : memory accepts the beat
//   mem_waddr     : halfword-aligned beat address
//   mem_wdata     : beat data
//   mem_wbe       : byte enables, bit0 = low byte
// -----------------------------------------------------------------------------
module store_narrow16
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              done,
    output logic              err,
    output logic              mem_wvalid,
    input  logic              mem_wready,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [15:0]       mem_wdata,
    output logic [1:0]        mem_wbe
);

    // Address step between the two beats of a word store.
    localparam logic [ADDR_W-1:0] BEAT_STRIDE = ADDR_W'(2);

    store_state_e      state_q,   state_d;
    logic              ready_q,   ready_d;
    logic              done_q,    done_d;
    logic              err_q,     err_d;
    logic              wvalid_q,  wvalid_d;
    logic [ADDR_W-1:0] waddr_q,   waddr_d;
    logic [15:0]       wdata_q,   wdata_d;
    logic [1:0]        wbe_q,     wbe_d;
    // Captured request fields still needed after the accept edge.
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [15:0]       data_hi_q, data_hi_d;
    logic [1:0]        size_q,    size_d;

    logic              beat_hs_s;

    assign beat_hs_s = wvalid_q & mem_wready;

    // Next-state, lane steering and pulse generation.
    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        wvalid_d  = wvalid_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wbe_d     = wbe_q;
        addr_d    = addr_q;
        data_hi_d = data_hi_q;
        size_d    = size_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d    = req_addr;
                    data_hi_d = req_data[31:16];
                    size_d    = req_size;
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = BEAT0;
                        wvalid_d = 1'b1;
                        if (req_size == SZ_BYTE) begin
                            // Byte is replicated on both lanes; the enable
                            // picks the lane addressed by addr[0].
                            waddr_d = {req_addr[ADDR_W-1:1], 1'b0};
                            wdata_d = {req_data[7:0], req_data[7:0]};
                            wbe_d   = req_addr[0] ? 2'b10 : 2'b01;
                        end else begin
                            // Half, or low half of a word.
                            waddr_d = req_addr;
                            wdata_d = req_data[15:0];
                            wbe_d   = 2'b11;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            BEAT0: begin
                if (beat_hs_s) begin
                    if (size_q == SZ_WORD) begin
                        // Load the upper half on the handshake edge so valid
                        // stays high with no bubble between beats.
                        state_d = BEAT1;
                        waddr_d = addr_q + BEAT_STRIDE;
                        wdata_d = data_hi_q;
                        wbe_d   = 2'b11;
                    end else begin
                        state_d  = IDLE;
                        wvalid_d = 1'b0;
                        done_d   = 1'b1;
                    end
                end else begin
                    state_d = BEAT0;
                end
            end

            BEAT1: begin
                if (beat_hs_s) begin
                    state_d  = IDLE;
                    wvalid_d = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    state_d = BEAT1;
                end
            end

            default: begin
                state_d  = IDLE;
                wvalid_d = 1'b0;
            end
        endcase

        // Ready is registered from the next state so it is high exactly
        // while the state register holds IDLE.
        ready_d = (state_d == IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wvalid_q  <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= 16'h0000;
            wbe_q     <= 2'b00;
            addr_q    <= '0;
            data_hi_q <= 16'h0000;
            size_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            err_q     <= err_d;
            wvalid_q  <= wvalid_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wbe_q     <= wbe_d;
            addr_q    <= addr_d;
            data_hi_q <= data_hi_d;
            size_q    <= size_d;
        end
    end

    assign req_ready  = ready_q;
    assign done       = done_q;
    assign err        = err_q;
    assign mem_wvalid = wvalid_q;
    assign mem_waddr  = waddr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wbe    = wbe_q;

endmodule : store_narrow16
